// File: rtl/wb_icache_dm.sv
// Direct-mapped, one-word-per-line read cache on the instruction Wishbone path.
// Caches reads from one 256 MB region; everything else passes straight through.
module wb_icache_dm #(
    parameter int         IDX_W        = 4,
    parameter logic [3:0] CACHE_REGION = 4'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    input  logic [3:0]  s_sel_i,
    input  logic        s_we_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    output logic [31:0] s_data_o,
    output logic        s_ack_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    input  logic        inv_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        ACK,
        DRAIN
    } state_t;

    state_t state;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // set when the outstanding bus cycle is a cacheable read (fill on ack)
    logic pend_cache;

    logic [IDX_W-1:0] s_idx;
    logic [TAG_W-1:0] s_tag;
    logic [IDX_W-1:0] m_idx;
    logic [TAG_W-1:0] m_tag;
    logic             req;
    logic             cacheable;
    logic             hit;
    logic             bus_done;
    logic             fill_en;
    logic             wr_inv;

    assign s_idx     = s_addr_i[IDX_W+1:2];
    assign s_tag     = s_addr_i[31:IDX_W+2];
    assign m_idx     = m_addr_o[IDX_W+1:2];
    assign m_tag     = m_addr_o[31:IDX_W+2];
    assign req       = s_cyc_i & s_stb_i;
    assign cacheable = (s_addr_i[31:28] == CACHE_REGION) & ~s_we_i;
    assign hit       = valid[s_idx] && (tag_mem[s_idx] == s_tag);

    // a bus cycle completes in BUS or DRAIN; both update the cache the same way
    assign bus_done = ((state == BUS) || (state == DRAIN)) & m_ack_i;
    assign fill_en  = bus_done & pend_cache;
    assign wr_inv   = bus_done & m_we_o & valid[m_idx] &
                      (tag_mem[m_idx] == m_tag);

    // tag/data storage, written on fill only, never reset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[m_idx]  <= m_tag;
            data_mem[m_idx] <= m_data_i;
        end
    end

    // valid bits: invalidate-all beats a same-cycle fill or write-invalidate
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (inv_i) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[m_idx] <= 1'b1;
        end else if (wr_inv) begin
            valid[m_idx] <= 1'b0;
        end
    end

    // control FSM with registered CPU/bus outputs and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_cache <= 1'b0;
            s_data_o   <= '0;
            s_ack_o    <= 1'b0;
            m_addr_o   <= '0;
            m_data_o   <= '0;
            m_sel_o    <= '0;
            m_we_o     <= 1'b0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (cacheable && hit) begin
                            s_data_o <= data_mem[s_idx];
                            s_ack_o  <= 1'b1;
                            state    <= ACK;
                            if (hit_cnt_o != '1)
                                hit_cnt_o <= hit_cnt_o + 32'd1;
                        end else begin
                            m_addr_o   <= s_addr_i;
                            m_data_o   <= s_data_i;
                            m_sel_o    <= s_sel_i;
                            m_we_o     <= s_we_i;
                            m_cyc_o    <= 1'b1;
                            m_stb_o    <= 1'b1;
                            pend_cache <= cacheable;
                            state      <= BUS;
                            if (cacheable && (miss_cnt_o != '1))
                                miss_cnt_o <= miss_cnt_o + 32'd1;
                        end
                    end
                end
                BUS: begin
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        // CPU gone in the ack cycle: finish silently
                        if (s_cyc_i) begin
                            s_data_o <= m_data_i;
                            s_ack_o  <= 1'b1;
                            state    <= ACK;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!s_cyc_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACK: begin
                    s_ack_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_icache_dm.sv
// Randomized bench for wb_icache_dm against a line-keyed reference model.
// The bench acts as CPU master and as the bus slave on the m1 side.
module tb_wb_icache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_addr_i = '0;
    logic [31:0] s_data_i = '0;
    logic [3:0]  s_sel_i = '0;
    logic        s_we_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic [31:0] s_data_o;
    logic        s_ack_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic [31:0] m_data_i = '0;
    logic        m_ack_i = 1'b0;
    logic        inv_i = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int total = 0;
    int bad = 0;

    // reference model: each of 16 lines remembers the word address it holds
    bit          mv   [16];
    logic [31:0] mkey [16];
    logic [31:0] mdat [16];
    logic [31:0] hc = '0;
    logic [31:0] mc = '0;

    wb_icache_dm #(
        .IDX_W(4),
        .CACHE_REGION(4'h3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_addr_i(s_addr_i),
        .s_data_i(s_data_i),
        .s_sel_i(s_sel_i),
        .s_we_i(s_we_i),
        .s_cyc_i(s_cyc_i),
        .s_stb_i(s_stb_i),
        .s_data_o(s_data_o),
        .s_ack_o(s_ack_o),
        .m_addr_o(m_addr_o),
        .m_data_o(m_data_o),
        .m_sel_o(m_sel_o),
        .m_we_o(m_we_o),
        .m_cyc_o(m_cyc_o),
        .m_stb_o(m_stb_o),
        .m_data_i(m_data_i),
        .m_ack_i(m_ack_i),
        .inv_i(inv_i),
        .hit_cnt_o(hit_cnt_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) % 32'd16;
        return int'(k);
    endfunction

    function automatic bit is_cacheable(input logic [31:0] a, input logic we);
        return (a[31:28] == 4'h3) && !we;
    endfunction

    function automatic bit is_hit(input logic [31:0] a, input logic we);
        int li;
        li = line_of(a);
        return is_cacheable(a, we) && mv[li] && (mkey[li] == (a >> 2));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, hit_cnt_o, hc);
        check({tag, "_miss"}, miss_cnt_o, mc);
    endtask

    // one CPU access; the bench answers the bus after w wait cycles.
    // inv_mode raises inv_i together with the lookup (hit) or the fill (miss).
    task automatic access(input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [3:0] sel,
                          input logic [31:0] bd, input int w,
                          input bit inv_mode);
        int          li;
        bit          cach;
        bit          hit;
        bit          got;
        bit          prev;
        int          lat;
        int          ntx;
        int          waited;
        logic [31:0] dat;
        logic [31:0] ba;
        logic [31:0] bwd;
        logic [3:0]  bsel;
        logic        bwe;
        li     = line_of(a);
        cach   = is_cacheable(a, we);
        hit    = is_hit(a, we);
        got    = 1'b0;
        prev   = 1'b0;
        lat    = 0;
        ntx    = 0;
        waited = 0;
        dat    = '0;
        ba     = '0;
        bwd    = '0;
        bsel   = '0;
        bwe    = 1'b0;
        s_addr_i = a;
        s_we_i   = we;
        s_data_i = wd;
        s_sel_i  = sel;
        s_cyc_i  = 1'b1;
        s_stb_i  = 1'b1;
        if (inv_mode && hit) inv_i = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            inv_i = 1'b0;
            if (m_ack_i) begin
                m_ack_i = 1'b0;
            end else if (m_stb_o) begin
                if (!prev) begin
                    ntx++;
                    ba   = m_addr_o;
                    bwd  = m_data_o;
                    bsel = m_sel_o;
                    bwe  = m_we_o;
                end
                if (waited == w) begin
                    m_ack_i  = 1'b1;
                    m_data_i = bd;
                    if (inv_mode) inv_i = 1'b1;
                end else begin
                    waited++;
                end
            end
            prev = m_stb_o;
            if (s_ack_o) begin
                got = 1'b1;
                lat = c;
                dat = s_data_o;
                break;
            end
        end
        inv_i   = 1'b0;
        m_ack_i = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check("ack_pulse", 32'(s_ack_o), 32'd0);
        if (got) begin
            check("latency", 32'(lat), hit ? 32'd1 : 32'(w + 2));
            check("rdata", dat, hit ? mdat[li] : bd);
            check("bus_txns", 32'(ntx), hit ? 32'd0 : 32'd1);
            if (!hit) begin
                check("bus_addr", ba, a);
                check("bus_we", 32'(bwe), 32'(we));
                check("bus_sel", 32'(bsel), 32'(sel));
                if (we) check("bus_wdata", bwd, wd);
            end
        end
        if (hit) begin
            hc = sinc(hc);
        end else if (cach) begin
            mc = sinc(mc);
            mv[li]   = 1'b1;
            mkey[li] = a >> 2;
            mdat[li] = bd;
        end
        if (we && mv[li] && (mkey[li] == (a >> 2))) mv[li] = 1'b0;
        if (inv_mode) model_clear();
        check_counters("acc");
    endtask

    // cacheable read miss whose CPU cycle is dropped while the bus is busy
    task automatic drain(input logic [31:0] a, input logic [31:0] bd,
                         input int w);
        int li;
        int acks;
        int drop;
        li   = line_of(a);
        acks = 0;
        drop = 0;
        s_addr_i = a;
        s_we_i   = 1'b0;
        s_sel_i  = 4'hF;
        s_cyc_i  = 1'b1;
        s_stb_i  = 1'b1;
        @(posedge clk);
        #1;
        check("drain_cyc", 32'(m_cyc_o), 32'd1);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        for (int i = 0; i < w; i++) begin
            @(posedge clk);
            #1;
            if (!m_cyc_o) drop++;
            if (s_ack_o) acks++;
        end
        m_ack_i  = 1'b1;
        m_data_i = bd;
        @(posedge clk);
        #1;
        m_ack_i = 1'b0;
        if (s_ack_o) acks++;
        check("drain_release", 32'(m_cyc_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (s_ack_o) acks++;
        end
        check("drain_hold", 32'(drop), 32'd0);
        check("drain_noack", 32'(acks), 32'd0);
        mc = sinc(mc);
        mv[li]   = 1'b1;
        mkey[li] = a >> 2;
        mdat[li] = bd;
        check_counters("drain");
    endtask

    task automatic pulse_inv();
        inv_i = 1'b1;
        @(posedge clk);
        #1;
        inv_i = 1'b0;
        model_clear();
    endtask

    // reset arriving while a bus cycle is outstanding
    task automatic reset_mid();
        s_addr_i = 32'h3FFF_FFC0;
        s_we_i   = 1'b0;
        s_sel_i  = 4'hF;
        s_cyc_i  = 1'b1;
        s_stb_i  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_pre", 32'(m_cyc_o), 32'd1);
        rst     = 1'b1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_cyc", 32'(m_cyc_o), 32'd0);
        check("rst_mid_stb", 32'(m_stb_o), 32'd0);
        check("rst_mid_ack", 32'(s_ack_o), 32'd0);
        rst = 1'b0;
        hc  = '0;
        mc  = '0;
        model_clear();
        check_counters("rst_mid");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  reg_hi;
        logic        we;
        int          w;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ack", 32'(s_ack_o), 32'd0);
        check("rst_s_data", s_data_o, 32'd0);
        check("rst_m_cyc", 32'(m_cyc_o), 32'd0);
        check("rst_m_stb", 32'(m_stb_o), 32'd0);
        check("rst_m_we", 32'(m_we_o), 32'd0);
        check("rst_m_addr", m_addr_o, 32'd0);
        check("rst_m_data", m_data_o, 32'd0);
        check("rst_m_sel", 32'(m_sel_o), 32'd0);
        check_counters("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        access(32'h3000_0010, 1'b0, '0, 4'hF, 32'h1234_5678, 3, 1'b0);
        access(32'h3000_0010, 1'b0, '0, 4'hF, 32'hDEAD_0000, 2, 1'b0);
        access(32'h3000_0050, 1'b0, '0, 4'hF, 32'hAAAA_0001, 1, 1'b0);
        access(32'h3000_0010, 1'b0, '0, 4'hF, 32'h1234_5678, 0, 1'b0);
        access(32'h3000_0050, 1'b0, '0, 4'hF, 32'hAAAA_0001, 0, 1'b0);
        access(32'h3000_0050, 1'b1, 32'h5555_AAAA, 4'hF, '0, 1, 1'b0);
        access(32'h3000_0050, 1'b0, '0, 4'hF, 32'hAAAA_0002, 2, 1'b0);
        access(32'h0000_0100, 1'b0, '0, 4'hF, 32'h0BAD_F00D, 1, 1'b0);
        access(32'h0000_0100, 1'b0, '0, 4'hF, 32'h0BAD_F00E, 0, 1'b0);
        access(32'h3000_0020, 1'b0, '0, 4'hF, 32'h2020_2020, 0, 1'b0);
        access(32'h3000_0020, 1'b0, '0, 4'hF, '0, 0, 1'b0);
        pulse_inv();
        access(32'h3000_0020, 1'b0, '0, 4'hF, 32'h2020_2021, 0, 1'b0);
        drain(32'h3000_0030, 32'hC0DE_0030, 3);
        access(32'h3000_0030, 1'b0, '0, 4'hF, '0, 0, 1'b0);
        access(32'h3000_0040, 1'b0, '0, 4'hF, 32'h4040_0001, 1, 1'b1);
        access(32'h3000_0040, 1'b0, '0, 4'hF, 32'h4040_0002, 0, 1'b0);
        access(32'h3000_0040, 1'b0, '0, 4'hF, '0, 0, 1'b1);
        access(32'h3000_0040, 1'b0, '0, 4'hF, 32'h4040_0003, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       reg_hi = 4'h0;
                1:       reg_hi = 4'h5;
                default: reg_hi = 4'h3;
            endcase
            a  = {reg_hi, 20'h0, 2'($urandom), 4'($urandom), 2'b00};
            we = ($urandom_range(0, 4) == 0);
            w  = int'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) pulse_inv();
            if (($urandom_range(0, 14) == 0) && is_cacheable(a, we) &&
                !is_hit(a, we))
                drain(a, $urandom, w);
            else
                access(a, we, $urandom, 4'($urandom), $urandom, w,
                       ($urandom_range(0, 9) == 0));
        end

        reset_mid();
        access(32'h3000_0030, 1'b0, '0, 4'hF, 32'h3030_3030, 1, 1'b0);
        access(32'h3000_0030, 1'b0, '0, 4'hF, '0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
